sdr_tuning_controller: RTL

- Command decoder between `uart_rx` (upstream) and the NCO / CIC gain inputs (downstream).
- Turns received UART bytes into a registered phase increment and CIC gain.
- Supports single-byte presets and steps, plus a multi-byte direct hex load of the phase increment.
- Replaces the ad-hoc byte `case` logic in the top level; unknown bytes never disturb the tuning.

---
 rtl/sdr_tuning_controller_if.sv | 23 ++
 rtl/sdr_tuning_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sdr_tuning_controller_if.sv
// Byte command bus from uart_rx into the tuning controller, plus the tuning outputs it drives.
interface sdr_tuning_controller_if #(
  parameter int unsigned PHASE_WIDTH = 64,
  parameter int unsigned GAIN_WIDTH  = 2
);
  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic [PHASE_WIDTH-1:0] phase_increment;
  logic [GAIN_WIDTH-1:0]  cic_gain;
  logic                   phase_update;
  logic                   cmd_error;
  logic                   busy;

  modport master (
    output rx_valid, rx_byte,
    input  phase_increment, cic_gain, phase_update, cmd_error, busy
  );

  modport slave (
    input  rx_valid, rx_byte,
    output phase_increment, cic_gain, phase_update, cmd_error, busy
  );
endinterface

// File: rtl/sdr_tuning_controller.sv
// Decodes received UART bytes into the NCO phase increment and CIC gain select:
// single-byte presets/steps/gains, plus an 'F' + hex digits + CR direct load.
module sdr_tuning_controller #(
  parameter int unsigned PHASE_WIDTH  = 64,
  parameter int unsigned GAIN_WIDTH   = 2,
  parameter int unsigned TIMEOUT_CLKS = 8000000,
  parameter logic [PHASE_WIDTH-1:0] RESET_PHASE_INC = PHASE_WIDTH'(64'h04CF41F212D77318),
  parameter logic [PHASE_WIDTH-1:0] STEP_9K         = PHASE_WIDTH'(64'h00071B375868D170),
  parameter logic [PHASE_WIDTH-1:0] STEP_1K         = PHASE_WIDTH'(64'h0000CA22980BA57E),
  parameter logic [PHASE_WIDTH-1:0] STEP_100        = PHASE_WIDTH'(64'h00001436A8CDF6F3)
) (
  input  logic                   clk,
  input  logic                   arst,
  sdr_tuning_controller_if.slave bus
);
  localparam int unsigned NUM_DIGITS = PHASE_WIDTH / 4;
  localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TMR_W      = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [PHASE_WIDTH-1:0] PRESET_B = PHASE_WIDTH'(64'h01AA60F8B8911654);
  localparam logic [PHASE_WIDTH-1:0] PRESET_F = PHASE_WIDTH'(64'h1DC38C076704516D);
  localparam logic [PHASE_WIDTH-1:0] PRESET_G = PHASE_WIDTH'(64'h1D60D923295482C6);

  typedef enum logic [1:0] {IDLE, HEX, TERM} state_t;

  state_t                 state_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [PHASE_WIDTH-1:0] shift_q;
  logic [GAIN_WIDTH-1:0]  gain_q;
  logic [CNT_W-1:0]       count_q;
  logic [TMR_W-1:0]       timer_q;
  logic                   update_q;
  logic                   error_q;
  logic                   busy_q;
  logic [4:0]             digit_c;

  // {valid, nibble} for an ASCII hex digit of either case
  function automatic logic [4:0] hex_digit(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)      return {1'b1, 4'(b - 8'h30)};
    else if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
    else if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
    else                               return 5'b0;
  endfunction

  assign digit_c = hex_digit(bus.rx_byte);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      phase_q  <= RESET_PHASE_INC;
      shift_q  <= '0;
      gain_q   <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      error_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (bus.rx_valid) begin
            case (bus.rx_byte)
              8'h30, 8'h31, 8'h32, 8'h33: gain_q <= GAIN_WIDTH'(bus.rx_byte - 8'h30);
              8'h61: begin phase_q <= RESET_PHASE_INC;      update_q <= 1'b1; end
              8'h62: begin phase_q <= PRESET_B;             update_q <= 1'b1; end
              8'h66: begin phase_q <= PRESET_F;             update_q <= 1'b1; end
              8'h67: begin phase_q <= PRESET_G;             update_q <= 1'b1; end
              8'h6D: begin phase_q <= phase_q + STEP_9K;    update_q <= 1'b1; end
              8'h6E: begin phase_q <= phase_q - STEP_9K;    update_q <= 1'b1; end
              8'h72: begin phase_q <= phase_q + STEP_1K;    update_q <= 1'b1; end
              8'h71: begin phase_q <= phase_q - STEP_1K;    update_q <= 1'b1; end
              8'h70: begin phase_q <= phase_q + STEP_100;   update_q <= 1'b1; end
              8'h6F: begin phase_q <= phase_q - STEP_100;   update_q <= 1'b1; end
              8'h46: begin
                state_q <= HEX;
                shift_q <= '0;
                count_q <= '0;
                busy_q  <= 1'b1;
              end
              default: error_q <= 1'b1;
            endcase
          end
        end
        HEX: begin
          if (bus.rx_valid) begin
            timer_q <= '0;
            if (digit_c[4]) begin
              shift_q <= {shift_q[PHASE_WIDTH-5:0], digit_c[3:0]};
              count_q <= count_q + 1'b1;
              if (count_q == CNT_W'(NUM_DIGITS - 1)) state_q <= TERM;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
            error_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        TERM: begin
          if (bus.rx_valid) begin
            timer_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bus.rx_byte == 8'h0D) begin
              phase_q  <= shift_q;
              update_q <= 1'b1;
            end else begin
              error_q  <= 1'b1;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
            error_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase_increment = phase_q;
  assign bus.cic_gain        = gain_q;
  assign bus.phase_update    = update_q;
  assign bus.cmd_error       = error_q;
  assign bus.busy            = busy_q;
endmodule
